// File: rtl/mem_access_stage.sv
// mem_access_stage: EX/MEM consumer; decodes MEM bits, runs a req/ack data-memory handshake and registers the MEM/WB bundle.
// Optional REQ timeout with err_o pulse enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic [1:0]        WB_i,
    input  logic [1:0]        MEM_i,
    input  logic [15:0]       FU_result_i,
    input  logic [15:0]       RT_data_i,
    input  logic [2:0]        Write_dst_i,
    output logic              stall_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [15:0]       dmem_wdata_o,
    input  logic              dmem_ack_i,
    input  logic [15:0]       dmem_rdata_i,
    output logic [1:0]        WB_o,
    output logic [15:0]       mem_data_o,
    output logic [15:0]       FU_result_o,
    output logic [2:0]        Write_dst_o,
    output logic              err_o
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t      r_state;
    logic [15:0] r_fu;
    logic [15:0] r_wdata;
    logic        r_we;
    logic [1:0]  r_wb;
    logic [2:0]  r_dst;
    logic        w_dec;
    logic        w_memop;
    logic        w_to;
    assign w_dec        = r_state != REQ;
    assign w_memop      = w_dec && (MEM_i[1] ^ MEM_i[0]);
    assign stall_o      = !w_dec || w_memop;
    assign dmem_req_o   = !w_dec;
    assign dmem_we_o    = r_we;
    assign dmem_addr_o  = r_fu[ADDR_W-1:0];
    assign dmem_wdata_o = r_wdata;
`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
    logic          r_err;
    assign w_to  = r_cnt == CW'(TIMEOUT - 1);
    assign err_o = r_err;
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= !w_dec && !dmem_ack_i && w_to;
            r_cnt <= w_dec ? '0 : r_cnt + 1'b1;
        end
    end
`else
    assign w_to  = TIMEOUT < 0;
    assign err_o = 1'b0;
`endif
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_fu        <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_wb        <= '0;
            r_dst       <= '0;
            WB_o        <= '0;
            mem_data_o  <= '0;
            FU_result_o <= '0;
            Write_dst_o <= '0;
        end else if (w_memop) begin
            r_state <= REQ;
            r_fu    <= FU_result_i;
            r_wdata <= RT_data_i;
            r_we    <= MEM_i[0];
            r_wb    <= WB_i;
            r_dst   <= Write_dst_i;
            WB_o    <= '0;
        end else if (w_dec) begin
            r_state     <= IDLE;
            WB_o        <= (MEM_i == 2'b11) ? 2'b00 : WB_i;
            mem_data_o  <= '0;
            FU_result_o <= FU_result_i;
            Write_dst_o <= Write_dst_i;
        end else if (dmem_ack_i) begin
            r_state     <= DONE;
            WB_o        <= r_wb;
            mem_data_o  <= r_we ? 16'h0 : dmem_rdata_i;
            FU_result_o <= r_fu;
            Write_dst_o <= r_dst;
        end else if (w_to) begin
            r_state    <= DONE;
            WB_o       <= '0;
            mem_data_o <= '0;
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: scoreboard bench; driver pushes per-edge expected bundles, negedge monitor pops and compares.
module tb_mem_access_stage;
    localparam int TO = 4;
    logic        clk_i = 0;
    logic        rst_n;
    logic [1:0]  WB_i, MEM_i;
    logic [15:0] FU_result_i, RT_data_i;
    logic [2:0]  Write_dst_i;
    logic        stall_o, dmem_req_o, dmem_we_o;
    logic [7:0]  dmem_addr_o;
    logic [15:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [15:0] dmem_rdata_i;
    logic [1:0]  WB_o;
    logic [15:0] mem_data_o, FU_result_o;
    logic [2:0]  Write_dst_o;
    logic        err_o;
    int total = 0, bad = 0, cyc = 0;

    mem_access_stage #(.ADDR_W(8), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_n(rst_n), .WB_i(WB_i), .MEM_i(MEM_i),
        .FU_result_i(FU_result_i), .RT_data_i(RT_data_i), .Write_dst_i(Write_dst_i),
        .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .WB_o(WB_o), .mem_data_o(mem_data_o), .FU_result_o(FU_result_o),
        .Write_dst_o(Write_dst_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [1:0]  wb;
        logic [15:0] md, fu;
        logic [2:0]  dst;
        logic        req, err, cmd, cfd;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] wb, input logic [15:0] md, input logic [15:0] fu,
                        input logic [2:0] dst, input logic req, input logic err,
                        input logic cmd, input logic cfd);
        exp_t e;
        e.cyc = cyc + 1; e.wb = wb; e.md = md; e.fu = fu; e.dst = dst;
        e.req = req; e.err = err; e.cmd = cmd; e.cfd = cfd;
        q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    initial forever begin
        @(negedge clk_i);
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("order", e.cyc, cyc);
            chk("WB_o", WB_o, e.wb);
            chk("dmem_req_o", dmem_req_o, e.req);
            chk("err_o", err_o, e.err);
            if (e.cmd) chk("mem_data_o", mem_data_o, e.md);
            if (e.cfd) begin
                chk("FU_result_o", FU_result_o, e.fu);
                chk("Write_dst_o", Write_dst_o, e.dst);
            end
        end
    end

    task automatic issue(input logic [1:0] wb, input logic [1:0] mem, input logic [15:0] fu,
                         input logic [15:0] rt, input logic [2:0] dst, input int n,
                         input logic [15:0] rd);
        bit memop;
        memop = (mem == 2'b01) || (mem == 2'b10);
        WB_i = wb; MEM_i = mem; FU_result_i = fu; RT_data_i = rt; Write_dst_i = dst;
        dmem_ack_i = !memop && ($urandom_range(0, 3) == 0);
        #1;
        chk("stall_o decode", stall_o, memop);
        if (!memop) begin
            push(mem == 2'b11 ? 2'b00 : wb, 16'h0, fu, dst, 1'b0, 1'b0, 1'b1, 1'b1);
            tick;
            dmem_ack_i = 0;
            return;
        end
        push(2'b00, 16'h0, fu, dst, 1'b1, 1'b0, 1'b0, 1'b0);
        tick;
        for (int i = 0; i <= n; i++) begin
            chk("stall_o req", stall_o, 1'b1);
            chk("dmem_we_o", dmem_we_o, mem[0]);
            chk("dmem_addr_o", dmem_addr_o, fu[7:0]);
            if (mem[0]) chk("dmem_wdata_o", dmem_wdata_o, rt);
            if (i < n) begin
                push(2'b00, 16'h0, fu, dst, 1'b1, 1'b0, 1'b0, 1'b0);
                tick;
            end
        end
        dmem_ack_i = 1; dmem_rdata_i = rd;
        push(wb, mem[0] ? 16'h0 : rd, fu, dst, 1'b0, 1'b0, 1'b1, 1'b1);
        tick;
        dmem_ack_i = 0; dmem_rdata_i = 16'($urandom);
    endtask

    initial begin
        rst_n = 0; WB_i = 2'b11; MEM_i = 2'b00; FU_result_i = 16'hA5A5; RT_data_i = 16'h5A5A;
        Write_dst_i = 3'd7; dmem_ack_i = 0; dmem_rdata_i = 16'h0;
        repeat (2) begin
            push(2'b00, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
            tick;
        end
        rst_n = 1;
        issue(2'b10, 2'b00, 16'h1234, 16'h0, 3'd3, 0, 16'h0);
        issue(2'b11, 2'b10, 16'h0042, 16'h0, 3'd5, 2, 16'hBEEF);
        issue(2'b00, 2'b01, 16'h0010, 16'h00FF, 3'd1, 0, 16'h0);
        issue(2'b10, 2'b11, 16'h7777, 16'h1, 3'd2, 0, 16'h0);
        WB_i = 2'b11; MEM_i = 2'b10; FU_result_i = 16'h0099; Write_dst_i = 3'd4;
        push(2'b00, 16'h0, 16'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick;
        push(2'b00, 16'h0, 16'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick;
        rst_n = 0; WB_i = 2'b00; MEM_i = 2'b00; FU_result_i = 16'h0; Write_dst_i = 3'd0;
        push(2'b00, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick;
        rst_n = 1; dmem_ack_i = 1; dmem_rdata_i = 16'hDEAD;
        repeat (3) begin
            push(2'b00, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
            tick;
        end
        dmem_ack_i = 0;
`ifdef MEM_TIMEOUT_EN
        WB_i = 2'b11; MEM_i = 2'b10; FU_result_i = 16'h0033; Write_dst_i = 3'd6;
        #1;
        chk("stall_o timeout", stall_o, 1'b1);
        for (int i = 0; i < TO; i++) begin
            push(2'b00, 16'h0, 16'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
            tick;
        end
        WB_i = 2'b00; MEM_i = 2'b00;
        q[$].req = 1'b0; q[$].err = 1'b1; q[$].cmd = 1'b1;
        issue(2'b10, 2'b00, 16'h4321, 16'h0, 3'd1, 0, 16'h0);
`endif
        for (int k = 0; k < 80; k++)
            issue(2'($urandom), 2'($urandom), 16'($urandom), 16'($urandom), 3'($urandom),
                  $urandom_range(0, TO - 1), 16'($urandom));
        WB_i = 2'b00; MEM_i = 2'b00;
        repeat (3) @(negedge clk_i);
        chk("scoreboard drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
